// File: rtl/mem_read_responder.sv
// Memory-side read/write responder for the cache fill path: single-port word
// array with a fixed-latency, fully pipelined read return.
module mem_read_responder #(
  parameter int LATENCY = 4,
  parameter int AW      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        pending
);

  logic [15:0] mem [2**AW];

  logic [LATENCY-1:0]       vld_pipe;
  logic [LATENCY-1:0][15:0] dat_pipe;

  logic [AW-1:0] idx;
  logic          rd_acc;
  logic          unused_addr;

  assign idx         = addr[AW:1];
  assign rd_acc      = enable && !wr;
  // Byte-select bit and high address bits alias away.
  assign unused_addr = ^{addr[0], addr[15:AW+1]};

  // The array is deliberately left out of reset; requests during reset drop.
  always_ff @(posedge clk) begin
    if (!rst && enable && wr) mem[idx] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      dat_pipe[0] <= rd_acc ? mem[idx] : 16'h0000;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign data_valid = vld_pipe[LATENCY-1];
  assign data_out   = vld_pipe[LATENCY-1] ? dat_pipe[LATENCY-1] : 16'h0000;

  // The output stage is not counted: pending drops in the return cycle.
  generate
    if (LATENCY > 1) begin : g_pend
      assign pending = |vld_pipe[LATENCY-2:0];
    end else begin : g_nopend
      assign pending = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed + randomized bench for mem_read_responder against a cycle-scheduled
// reference model (per-cycle return table plus a word-array model).
module tb_mem_read_responder;
  localparam int L  = 4;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst, enable, wr;
  logic [15:0] addr, data_in;
  logic [15:0] data_out;
  logic        data_valid, pending;

  mem_read_responder #(.LATENCY(L), .AW(AW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          vectors = 0;
  int          errs = 0;
  bit          armed = 0;
  logic [15:0] mem_m  [int];
  logic [15:0] ret_at [int];

  function automatic int widx(input logic [15:0] a);
    return (int'(a) >> 1) % (2**AW);
  endfunction

  task automatic check_outputs();
    logic        ev, ep;
    logic [15:0] ed;
    ev = ret_at.exists(cyc);
    ed = ev ? ret_at[cyc] : 16'h0000;
    ep = 1'b0;
    foreach (ret_at[k]) if (k > cyc && k < cyc + L) ep = 1'b1;
    vectors++;
    assert (data_valid === ev) else begin
      errs++; $error("FAIL data_valid cyc=%0d got %b exp %b", cyc, data_valid, ev);
    end
    vectors++;
    assert (data_out === ed) else begin
      errs++; $error("FAIL data_out cyc=%0d got %h exp %h", cyc, data_out, ed);
    end
    vectors++;
    assert (pending === ep) else begin
      errs++; $error("FAIL pending cyc=%0d got %b exp %b", cyc, pending, ep);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
    int drop[$];
    rst = r; enable = en; wr = w; addr = a; data_in = d;
    @(negedge clk);
    if (armed) check_outputs();
    if (ret_at.exists(cyc)) ret_at.delete(cyc);
    if (r) begin
      foreach (ret_at[k]) if (k > cyc) drop.push_back(k);
      foreach (drop[j]) ret_at.delete(drop[j]);
    end else if (en && w) begin
      mem_m[widx(a)] = d;
    end else if (en) begin
      ret_at[cyc + L] = mem_m[widx(a)];
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    step(0, 1, 1, a, d);
  endtask

  task automatic rd_word(input logic [15:0] a);
    step(0, 1, 0, a, 16'h0);
  endtask

  initial begin
    rst = 1; enable = 0; wr = 0; addr = 0; data_in = 0;
    @(posedge clk); #1;
    // Power-up reset; outputs are only defined after the first reset edge.
    step(1, 0, 0, 16'h0, 16'h0);
    armed = 1;
    step(1, 0, 0, 16'h0, 16'h0);
    idle(1);

    // Reset values with random request noise; pre-written word must survive.
    wr_word(16'h0010, 16'h5A3C);
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    idle(1);
    rd_word(16'h0010);
    idle(L + 1);

    // Single read.
    wr_word(16'h0040, 16'hBEEF);
    rd_word(16'h0040);
    idle(L + 2);

    // Line fill.
    for (int i = 0; i < 8; i++) wr_word(16'(16'h0100 + 2*i), 16'(16'h1000 + i));
    for (int i = 0; i < 8; i++) rd_word(16'(16'h0100 + 2*i));
    idle(L + 2);

    // Write while an earlier read of the same word is in flight.
    wr_word(16'h0022, 16'h1111);
    rd_word(16'h0022);
    wr_word(16'h0022, 16'h2222);
    rd_word(16'h0022);
    idle(L + 2);

    // Reset mid-flight.
    for (int i = 0; i < 3; i++) rd_word(16'h0040);
    step(1, 0, 0, 16'h0, 16'h0);
    idle(L + 2);

    // Aliasing with a bubble.
    wr_word(16'h0006, 16'hA5A5);
    rd_word(16'h0007);
    idle(1);
    rd_word(16'h0806);
    idle(L + 2);

    // Randomized traffic over a small aliased window, occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic        r, en, w;
      a  = 16'($urandom_range(0, 63)) | (16'($urandom_range(0, 31)) << 11);
      r  = ($urandom_range(0, 59) == 0);
      en = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      if (!r && en && !w && !mem_m.exists(widx(a))) w = 1'b1;
      step(r, en, w, a, 16'($urandom));
    end
    idle(L + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_read_responder.md
# mem_read_responder

Memory-side responder for the cache fill path: accepts one read or write request per cycle on a 16-bit byte-addressed bus and backs it with a word array. Read data returns after a fixed, parameterized latency with a one-cycle valid strobe, which is the `memory_data_valid` / data pair the cache fill controller consumes. Reads are fully pipelined, so an 8-word line fill issued on consecutive cycles returns on 8 consecutive cycles. Sits between the I/D cache fill logic and the (arbitrated) main-memory request port.

## Interface
- `LATENCY`, 4, cycles from read acceptance to `data_valid`; legal range 1–8.
- `AW`, 10, word-address width of the array (2^AW 16-bit words).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: request present this cycle.
- `wr` input 1: 1 = write, 0 = read; ignored when `enable`=0.
- `addr` input 16: byte address.
  - Word index is `addr[AW:1]`.
  - `addr[0]` and `addr[15:AW+1]` are ignored, so addresses alias modulo 2^(AW+1) bytes.
- `data_in` input 16: write data.
- `data_out` output 16: read data; meaningful only while `data_valid`=1, and 16'h0000 otherwise.
- `data_valid` output 1: one-cycle strobe per accepted read.
- `pending` output 1: at least one read is in flight (accepted, not yet returned).

## Operation
- No backpressure: every cycle with `enable`=1 is accepted. There is no stall or ready signal.
- Write (`enable`=1, `wr`=1):
  - The array word is updated at the rising edge ending the cycle.
  - No `data_valid` is produced for a write.
- Read (`enable`=1, `wr`=0):
  - The array word is sampled in the acceptance cycle, before any write in that same cycle. A write and a read cannot coincide because the port is single.
  - The sampled word and a valid bit enter a LATENCY-deep shift pipeline.
  - Returned data reflects array contents at acceptance. A later write to the same address while the read is in flight does not alter the returned data.
- Pipeline structure:
  - LATENCY stages, each holding a valid bit and 16-bit data.
  - Stage 0 loads `{read_accepted, sampled_word}` every cycle. When no read is accepted, it loads valid=0 and data=0.
  - Stage i loads from stage i-1 every cycle.
  - Outputs are driven from the last stage: `data_valid` = last.valid, `data_out` = last.valid ? last.data : 0.
- `pending` = OR of all stage valid bits, excluding the last stage's output cycle. It is high from the cycle after acceptance through the cycle before `data_valid` of the final outstanding read.
- In-flight count is implicit (at most LATENCY reads in flight). No counter saturation case exists.
- The array is not cleared by reset. Reads of never-written words return X in simulation, and benches write before reading.

## Timing
- Reset:
  - While `rst`=1 at a rising edge, all stage valid bits and data clear to 0.
  - After that edge: `data_valid`=0, `data_out`=16'h0000, `pending`=0.
  - Requests presented in a cycle with `rst`=1 are dropped, including writes, so the array is unchanged.
- Reset mid-operation: every in-flight read is discarded. No `data_valid` is produced for any read accepted before the reset edge.
- Read latency: a read accepted in cycle 0 (sampled at the edge ending cycle 0) shows `data_valid`=1 with its data during cycle LATENCY, for exactly one cycle.
- Throughput: one read per cycle. N back-to-back reads in cycles 0..N-1 return in cycles LATENCY..LATENCY+N-1, in order, with no gaps.
- Gaps: idle request cycles propagate as `data_valid`=0 bubbles, in the same relative positions.
- Write visibility: a write in cycle k is visible to a read accepted in cycle k+1 or later.
- LATENCY=1: read in cycle 0 returns in cycle 1, and `pending` never asserts.

## Test plan
- Reset values:
  - Stimulus: hold `rst`=1 for 2 cycles with random `enable`/`addr`.
  - Required: `data_valid`=0, `data_out`=0000, `pending`=0 throughout and on the first cycle after deassert; a subsequent read of a pre-written word returns its pre-reset value.
- Single read, LATENCY=4:
  - Stimulus: write 16'hBEEF to 0x0040, then read 0x0040 in cycle 0.
  - Required: `data_valid`=1 with `data_out`=BEEF in cycle 4 only; `pending`=1 in cycles 1–3.
- Line fill:
  - Stimulus: preload words 0x1000+i at addresses 0x0100+2i for i=0..7, then read 0x0100..0x010E on 8 consecutive cycles starting in cycle 0.
  - Required: `data_valid`=1 in cycles 4–11 with data 1000..1007 in order, and 0 in cycle 12.
- Write-after-read in flight:
  - Stimulus: address 0x0022 holds 0x1111; read it in cycle 0, write 0x2222 to it in cycle 1, read it again in cycle 2.
  - Required: cycle 4 returns 1111; cycle 6 returns 2222.
- Reset mid-flight:
  - Stimulus: reads in cycles 0–2, `rst`=1 in cycle 3.
  - Required: no `data_valid` in cycles 4–8; `pending`=0 from cycle 4.
- Aliasing and bubbles:
  - Stimulus: write 0xA5A5 to 0x0006; read 0x0007, then idle one cycle, then read 0x0806 (AW=10).
  - Required: both reads return A5A5, with a one-cycle `data_valid`=0 gap between the two returns.
